// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and sizing for the two-master RAM port arbiter.
// Pure declarations: no latency, no backpressure.
package ram_port_arbiter_pkg;

   localparam int N_PORTS = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RSP_HOLD = 2'd2
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(N_PORTS);

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request and read-response channels of every master sharing the RAM port.
// Wires only: no latency; valid/ready backpressure on both channels.
interface ram_port_arbiter_if
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);

   logic [N_PORTS-1:0]                 req_vld;
   logic [N_PORTS-1:0]                 req_rdy;
   logic [N_PORTS-1:0]                 req_we;
   logic [N_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [N_PORTS-1:0][DATA_WIDTH-1:0] req_din;
   logic [N_PORTS-1:0]                 rsp_vld;
   logic [N_PORTS-1:0]                 rsp_rdy;
   logic [DATA_WIDTH-1:0]              rsp_data;

   modport master (
      output req_vld, req_we, req_addr, req_din, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_data
   );

   modport slave (
      input  req_vld, req_we, req_addr, req_din, rsp_rdy,
      output req_rdy, rsp_vld, rsp_data
   );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Combinational 2-way round-robin grant; prio names the favoured requester.
// Zero latency; no grant at all while enable is low.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       enable,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      if (enable) begin
         // A lone requester wins even when it is not favoured.
         gnt_idx      = req[prio] ? prio : ~prio;
         gnt[gnt_idx] = req[gnt_idx];
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between two masters, round-robin.
// Writes retire on grant; a read holds the port until its response is accepted.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_port_arbiter_if.slave     bus,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam logic [1:0] S_IDLE     = IDLE;
   localparam logic [1:0] S_RD_WAIT  = RD_WAIT;
   localparam logic [1:0] S_RSP_HOLD = RSP_HOLD;

   logic [1:0]            state_q, state_d;
   logic                  prio_q, prio_d;
   logic                  owner_q, owner_d;
   logic [DATA_WIDTH-1:0] rsp_reg_q, rsp_reg_d;

   logic [1:0] gnt;
   logic       gnt_idx;
   logic       arb_en;

   assign arb_en = (state_q == S_IDLE) && !rst;

   rr_arbiter_2 u_arb (
      .req     (bus.req_vld),
      .prio    (prio_q),
      .enable  (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      owner_d      = owner_q;
      rsp_reg_d    = rsp_reg_q;
      bus.req_rdy  = gnt;
      bus.rsp_vld  = '0;
      bus.rsp_data = '0;
      ram_en       = |gnt;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_din      = '0;

      case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               ram_we   = bus.req_we[gnt_idx];
               ram_addr = bus.req_addr[gnt_idx];
               ram_din  = bus.req_din[gnt_idx];
               prio_d   = ~gnt_idx;
               if (!bus.req_we[gnt_idx]) begin
                  owner_d = gnt_idx;
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            rsp_reg_d = ram_dout;
            state_d   = S_RSP_HOLD;
         end
         S_RSP_HOLD: begin
            // A response pending at reset is dropped, never presented.
            if (!rst) begin
               bus.rsp_vld[owner_q] = 1'b1;
               bus.rsp_data         = rsp_reg_q;
               if (bus.rsp_rdy[owner_q]) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         prio_q    <= 1'b0;
         owner_q   <= 1'b0;
         rsp_reg_q <= '0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         owner_q   <= owner_d;
         rsp_reg_q <= rsp_reg_d;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter with a behavioural 4 x 8 RAM.
// Stimulus pushes expected grants and responses; a monitor pops and compares.
module tb_ram_port_arbiter;

   typedef struct {
      int         port;
      logic       we;
      logic [1:0] addr;
      logic [7:0] din;
   } gnt_t;

   typedef struct {
      int         port;
      logic [7:0] data;
   } rsp_t;

   logic       clk;
   logic       rst;
   logic       ram_en;
   logic       ram_we;
   logic [1:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic [7:0] mem [4];

   gnt_t exp_gnt[$];
   rsp_t exp_rsp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

   ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout      <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push_gnt(input int port, input logic we, input logic [1:0] addr, input logic [7:0] din);
      gnt_t g;
      g.port = port; g.we = we; g.addr = addr; g.din = din;
      exp_gnt.push_back(g);
   endtask

   task automatic push_rsp(input int port, input logic [7:0] data);
      rsp_t r;
      r.port = port; r.data = data;
      exp_rsp.push_back(r);
   endtask

   initial begin : monitor
      gnt_t g;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.req_rdy != 2'b00) begin
               if (exp_gnt.size() == 0) begin
                  check("unexpected_grant", {30'd0, bus.req_rdy}, 0);
               end else begin
                  g = exp_gnt.pop_front();
                  check("gnt_port", {30'd0, bus.req_rdy}, (g.port == 0) ? 1 : 2);
                  check("gnt_ram_en", {31'd0, ram_en}, 1);
                  check("gnt_ram_we", {31'd0, ram_we}, {31'd0, g.we});
                  check("gnt_ram_addr", {30'd0, ram_addr}, {30'd0, g.addr});
                  if (g.we) check("gnt_ram_din", {24'd0, ram_din}, {24'd0, g.din});
               end
            end else begin
               check("no_grant_ram_idle", {20'd0, ram_en, ram_we, ram_addr, ram_din}, 0);
            end
            if (bus.rsp_vld == 2'b11) check("rsp_onehot", {30'd0, bus.rsp_vld}, 1);
            for (int p = 0; p < 2; p++) begin
               if (bus.rsp_vld[p] && bus.rsp_rdy[p]) begin
                  if (exp_rsp.size() == 0) begin
                     check("unexpected_rsp", p + 1, 0);
                  end else begin
                     r = exp_rsp.pop_front();
                     check("rsp_port", p, r.port);
                     check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, r.data});
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      ram_dout     = 8'h00;
      rst          = 1'b1;
      bus.rsp_rdy  = 2'b11;
      bus.req_vld  = 2'b11;
      bus.req_we   = 2'b11;
      bus.req_addr[0] = 2'd0; bus.req_din[0] = 8'h11;
      bus.req_addr[1] = 2'd1; bus.req_din[1] = 8'h22;

      // Reset held with both masters requesting.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_req_rdy", {30'd0, bus.req_rdy}, 0);
         check("rst_ram_en", {31'd0, ram_en}, 0);
         check("rst_rsp_vld", {30'd0, bus.rsp_vld}, 0);
      end
      step;

      // Contended writes alternate starting with master 0.
      for (int i = 0; i < 2; i++) begin
         push_gnt(0, 1'b1, 2'd0, 8'h11);
         push_gnt(1, 1'b1, 2'd1, 8'h22);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("alt_grant", {30'd0, bus.req_rdy}, (i % 2 == 1) ? 2 : 1);
         step;
      end
      bus.req_vld = 2'b00;
      @(negedge clk);
      check("mem0_after_writes", {24'd0, mem[0]}, 32'h11);
      check("mem1_after_writes", {24'd0, mem[1]}, 32'h22);
      step;

      // Master 1 reads addr1: response two cycles after grant.
      bus.req_vld[1] = 1'b1; bus.req_we[1] = 1'b0;
      bus.req_addr[1] = 2'd1; bus.req_din[1] = 8'h00;
      push_gnt(1, 1'b0, 2'd1, 8'h00);
      push_rsp(1, 8'h22);
      @(negedge clk);
      check("rd_grant_m1", {30'd0, bus.req_rdy}, 2);
      step;
      bus.req_vld[1] = 1'b0;
      @(negedge clk);
      check("rd_wait_no_rsp", {30'd0, bus.rsp_vld}, 0);
      step;
      @(negedge clk);
      check("rd_rsp_lat2", {30'd0, bus.rsp_vld}, 2);
      step;

      // Response backpressure on master 0 while master 1 waits with a write.
      bus.rsp_rdy[0] = 1'b0;
      bus.req_vld = 2'b11;
      bus.req_we[0] = 1'b0; bus.req_addr[0] = 2'd0; bus.req_din[0] = 8'h00;
      bus.req_we[1] = 1'b1; bus.req_addr[1] = 2'd2; bus.req_din[1] = 8'h33;
      push_gnt(0, 1'b0, 2'd0, 8'h00);
      push_gnt(1, 1'b1, 2'd2, 8'h33);
      push_rsp(0, 8'h11);
      @(negedge clk);
      check("bp_grant_m0", {30'd0, bus.req_rdy}, 1);
      step;
      bus.req_vld[0] = 1'b0;
      @(negedge clk);
      check("bp_rd_wait_block", {30'd0, bus.req_rdy}, 0);
      step;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_vld", {30'd0, bus.rsp_vld}, 1);
         check("bp_rsp_data_held", {24'd0, bus.rsp_data}, 32'h11);
         check("bp_no_grant", {30'd0, bus.req_rdy}, 0);
         step;
      end
      bus.rsp_rdy[0] = 1'b1;
      @(negedge clk);
      check("bp_hs_cycle_block", {30'd0, bus.req_rdy}, 0);
      step;
      @(negedge clk);
      check("bp_grant_after_rsp", {30'd0, bus.req_rdy}, 2);
      step;
      bus.req_vld[1] = 1'b0;

      // Write and read to addr3 in the same cycle, write favoured.
      bus.req_vld = 2'b11;
      bus.req_we[0] = 1'b1; bus.req_addr[0] = 2'd3; bus.req_din[0] = 8'h5A;
      bus.req_we[1] = 1'b0; bus.req_addr[1] = 2'd3; bus.req_din[1] = 8'h00;
      push_gnt(0, 1'b1, 2'd3, 8'h5A);
      push_gnt(1, 1'b0, 2'd3, 8'h00);
      push_rsp(1, 8'h5A);
      @(negedge clk);
      check("raw_write_first", {30'd0, bus.req_rdy}, 1);
      step;
      bus.req_vld[0] = 1'b0;
      @(negedge clk);
      check("raw_read_second", {30'd0, bus.req_rdy}, 2);
      step;
      bus.req_vld[1] = 1'b0;
      @(negedge clk);
      step;
      @(negedge clk);
      check("raw_rsp_vld", {30'd0, bus.rsp_vld}, 2);
      step;

      // Reset while master 0's response is held.
      bus.rsp_rdy[0] = 1'b0;
      bus.req_vld[0] = 1'b1; bus.req_we[0] = 1'b0; bus.req_addr[0] = 2'd1;
      push_gnt(0, 1'b0, 2'd1, 8'h00);
      @(negedge clk);
      step;
      bus.req_vld[0] = 1'b0;
      @(negedge clk);
      step;
      @(negedge clk);
      check("hold_before_rst", {30'd0, bus.rsp_vld}, 1);
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      bus.rsp_rdy = 2'b11;
      bus.req_vld = 2'b11;
      bus.req_we  = 2'b11;
      bus.req_addr[0] = 2'd0; bus.req_din[0] = 8'h44;
      bus.req_addr[1] = 2'd2; bus.req_din[1] = 8'h55;
      push_gnt(0, 1'b1, 2'd0, 8'h44);
      push_gnt(1, 1'b1, 2'd2, 8'h55);
      @(negedge clk);
      check("rsp_dropped_after_rst", {30'd0, bus.rsp_vld}, 0);
      check("prio_reset_m0_wins", {30'd0, bus.req_rdy}, 1);
      step;
      bus.req_vld[0] = 1'b0;
      @(negedge clk);
      check("post_rst_m1_grant", {30'd0, bus.req_rdy}, 2);
      step;
      bus.req_vld[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_stale_rsp", {30'd0, bus.rsp_vld}, 0);
         step;
      end

      check("gnt_queue_drained", exp_gnt.size(), 0);
      check("rsp_queue_drained", exp_rsp.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter sharing one single-port synchronous RAM (1-cycle read latency, e.g. the 4 x 8-bit scratch RAM) between two independent masters. Each master sees a valid/ready request channel and a valid/ready read-response channel. The arbiter sequences RAM enable/write/address, captures read data and routes it back to the issuing master. It sits between the RAM macro and the datapath blocks that previously owned the RAM exclusively.

## Interface

- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 2, RAM address width (depth 2**ADDR_WIDTH)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_vld[n], n = 0..1  in  1  request valid from master n
- req_rdy[n]  out  1  request accepted this cycle
- req_we[n]  in  1  1 = write, 0 = read
- req_addr[n]  in  ADDR_WIDTH  RAM address
- req_din[n]  in  DATA_WIDTH  write data
- rsp_vld[n]  out  1  read data valid for master n
- rsp_rdy[n]  in  1  master n accepts read data
- rsp_data  out  DATA_WIDTH  read data, shared; meaningful only with a rsp_vld bit
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read strobe

## Operation

- FSM states: IDLE, RD_WAIT, RSP_HOLD.
- IDLE:
  - Arbitrate among asserted req_vld. Round-robin, 1-bit pointer `prio` names the favoured master.
  - Winner w gets req_rdy[w]=1 the same cycle (combinational from state, req_vld, prio). The loser's req_rdy=0.
  - ram_en=1, ram_we=req_we[w], ram_addr/ram_din from w.
  - prio <= ~w on every grant (read or write).
  - Write: stay in IDLE; a new grant is possible next cycle.
  - Read: latch owner <= w, go to RD_WAIT.
- RD_WAIT:
  - No grants; ram_en=0.
  - Capture ram_dout into rsp_reg and go to RSP_HOLD.
- RSP_HOLD:
  - rsp_vld[owner]=1, rsp_data=rsp_reg, no grants.
  - On rsp_rdy[owner]=1, go to IDLE.
  - rsp_data is held stable until accepted.
- Only one access is outstanding at a time. Writes never generate a response.
- Same-cycle requests from both masters: prio wins. Single requester: wins regardless of prio.
- req_rdy is never asserted outside IDLE. A master must keep req_vld and its payload stable until req_rdy.
- ram_en=0 and ram_we=0 whenever there is no grant.
- All outputs are 0 when no grant and no response is pending; ram_addr and ram_din are driven 0 when idle.

## Timing

- Reset (rst=1 at a clock edge) forces:
  - state IDLE, prio=0, owner=0, rsp_reg=0
  - all rsp_vld=0
- Reset mid-read or mid-RSP_HOLD drops the pending response silently. No rsp_vld is emitted after reset.
- While rst=1, req_rdy=0 and ram_en=0 regardless of state.
- Write latency: accepted in the cycle req_vld & req_rdy. The RAM updates at that edge.
- Read latency: grant at cycle T, ram_dout sampled at T+1, rsp_vld high from T+2. Next grant no earlier than the cycle rsp_rdy is seen plus 1.
- Peak throughput: 1 write/cycle; 1 read per 3 cycles with rsp_rdy held high.
- Back-to-back writes from both masters alternate strictly: 0,1,0,1...
- Read-after-write to the same address by the other master returns the new data: the write completes before the read grant.

## Structure

- Package ram_port_arbiter_pkg:
  - state enum {IDLE, RD_WAIT, RSP_HOLD}
  - N_PORTS=2
  - helper for the grant index width
- Sub-module rr_arbiter_2:
  - combinational 2-way round-robin grant
  - inputs: req[1:0], prio, enable
  - outputs: gnt one-hot, gnt_idx
  - Reusable for wider arbiters later.
- Top holds the FSM, prio/owner/rsp_reg registers and the RAM/response muxing.

## Test plan

- Reset: rst=1 for 2 cycles with both req_vld=1 → all req_rdy=0, ram_en=0, rsp_vld=0. After release the first grant goes to master 0.
- Contended writes: both masters write continuously (m0 addr0 data 0x11, m1 addr1 data 0x22) → grants alternate 0,1,0,1, one per cycle. RAM holds 0x11 at 0 and 0x22 at 1.
- Read path: m1 reads addr1 after the above → rsp_vld[1] asserted exactly 2 cycles after the grant, rsp_data=0x22, rsp_vld[0] stays 0.
- Response backpressure: m0 reads addr0 with rsp_rdy[0]=0 for 5 cycles while m1 requests → rsp_data held at 0x11, no req_rdy[1] until one cycle after rsp_rdy[0]=1.
- Read-after-write ordering: m0 writes 0x5A to addr3 while m1 reads addr3 in the same cycle with prio=0 → write granted first, m1 later receives 0x5A.
- Reset in RSP_HOLD: assert rst while rsp_vld[0]=1 → rsp_vld[0]=0 the next cycle, FSM in IDLE, prio=0, no stale response afterwards.
